// File: rtl/controle_busca_if.sv
// Instruction-fetch bus: imem read port, decode valid/ready handshake and
// branch/jump redirect.
interface controle_busca_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_data, dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_data, dec_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/controle_busca.sv
// Instruction-fetch sequencer: owns the PC and fetches one word at a time.
// Each word is held for the decoder until it is accepted or a redirect drops it.
module controle_busca #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter logic [31:0] MAX_PC   = 32'd6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    controle_busca_if.master   bus,
    output logic               halted,
    output logic [15:0]        inst_count
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] inst_r, inst_n;
    logic [31:0] ipc_r, ipc_n;
    logic        take;
    state_t      redir_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst_r     <= '0;
            ipc_r      <= '0;
            inst_count <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            inst_r <= inst_n;
            ipc_r  <= ipc_n;
            if (take && inst_count != 16'hFFFF)
                inst_count <= inst_count + 16'd1;
        end
    end

    // A redirect target past the program end parks the sequencer in HALT.
    assign redir_state = (bus.redirect_pc <= MAX_PC) ? FETCH : HALT;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst_r;
        ipc_n   = ipc_r;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = FETCH;
            end
            FETCH: begin
                if (bus.redirect) begin
                    pc_n    = bus.redirect_pc;
                    state_n = redir_state;
                end else if (bus.imem_ready) begin
                    inst_n  = bus.imem_data;
                    ipc_n   = pc;
                    pc_n    = pc + PC_STEP;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                take = bus.dec_ready;
                if (bus.redirect) begin
                    pc_n    = bus.redirect_pc;
                    state_n = redir_state;
                end else if (bus.dec_ready) begin
                    state_n = (pc <= MAX_PC) ? FETCH : HALT;
                end
            end
            HALT: begin
                if (bus.redirect) begin
                    pc_n    = bus.redirect_pc;
                    state_n = redir_state;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.imem_req   = (state == FETCH);
    assign bus.imem_addr  = (state == FETCH) ? pc : '0;
    assign bus.inst_valid = (state == HOLD);
    assign bus.inst       = inst_r;
    assign bus.inst_pc    = ipc_r;
    assign halted         = (state == HALT);
endmodule

// File: tb/tb_controle_busca.sv
// Directed bench for controle_busca: per-cycle vector table plus a short
// hand sequence showing outputs do not react combinationally to inputs.
module tb_controle_busca;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halted;
    logic [15:0] inst_count;

    controle_busca_if bus();

    controle_busca dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus.master),
        .halted     (halted),
        .inst_count (inst_count)
    );

    // Instruction memory: word n reads back as C0DE_nnnn.
    assign bus.imem_data = {16'hC0DE, bus.imem_addr[15:0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        r, s, ir, dr, rd;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] eipc;
        logic        eh;
        logic [15:0] ecnt;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int row    = 0;

    function automatic vec_t v(input int r, s, ir, dr, rd, input logic [31:0] rpc,
                               input int ereq, input logic [31:0] eaddr, input int ev,
                               input logic [31:0] eipc, input int eh, input int ecnt);
        vec_t t;
        t.r = r[0]; t.s = s[0]; t.ir = ir[0]; t.dr = dr[0]; t.rd = rd[0]; t.rpc = rpc;
        t.ereq = ereq[0]; t.eaddr = eaddr; t.ev = ev[0]; t.eipc = eipc;
        t.eh = eh[0]; t.ecnt = ecnt[15:0];
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    vec_t q[$];

    initial begin
        rst_n = 1'b0; start = 1'b0;
        bus.imem_ready = 1'b0; bus.dec_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;

        //          r s ir dr rd rpc           req addr v ipc h cnt
        q.push_back(v(0,0,0,0,0,0,             0,0,0,0,0,0));
        q.push_back(v(0,0,0,0,0,0,             0,0,0,0,0,0));
        q.push_back(v(1,0,0,0,0,0,             0,0,0,0,0,0));
        q.push_back(v(1,1,0,0,0,0,             1,0,0,0,0,0));
        q.push_back(v(1,0,1,0,0,0,             0,0,1,0,0,0));
        q.push_back(v(1,0,0,1,0,0,             1,1,0,0,0,1));
        q.push_back(v(1,0,1,0,0,0,             0,0,1,1,0,1));
        for (int i = 0; i < 5; i++)            // decoder stall at inst_pc=1
            q.push_back(v(1,0,1,0,0,0,         0,0,1,1,0,1));
        q.push_back(v(1,0,0,1,0,0,             1,2,0,1,0,2));
        for (int i = 0; i < 3; i++)            // memory wait at pc=2
            q.push_back(v(1,0,0,1,0,0,         1,2,0,1,0,2));
        q.push_back(v(1,0,1,0,0,0,             0,0,1,2,0,2));
        for (int p = 3; p <= 6; p++) begin
            q.push_back(v(1,0,0,1,0,0,         1,p,0,p-1,0,p));
            q.push_back(v(1,0,1,0,0,0,         0,0,1,p,0,p));
        end
        q.push_back(v(1,0,0,1,0,0,             0,0,0,6,1,7));
        q.push_back(v(1,0,1,1,0,0,             0,0,0,6,1,7));
        q.push_back(v(1,0,1,1,0,0,             0,0,0,6,1,7));
        q.push_back(v(1,0,0,0,1,0,             1,0,0,6,0,7));   // resume from HALT
        q.push_back(v(1,0,1,0,0,0,             0,0,1,0,0,7));
        q.push_back(v(1,0,0,1,0,0,             1,1,0,0,0,8));
        q.push_back(v(1,0,1,0,1,5,             1,5,0,0,0,8));   // redirect beats imem_ready
        q.push_back(v(1,0,1,0,0,0,             0,0,1,5,0,8));
        q.push_back(v(1,0,0,1,1,2,             1,2,0,5,0,9));   // redirect + dec_ready counts
        q.push_back(v(1,0,1,0,0,0,             0,0,1,2,0,9));
        q.push_back(v(1,0,0,0,1,9,             0,0,0,2,1,9));   // redirect out of program
        q.push_back(v(1,0,0,0,1,3,             1,3,0,2,0,9));
        q.push_back(v(1,0,0,0,1,32'hFFFF_FFFF, 0,0,0,2,1,9));   // unsigned compare
        q.push_back(v(1,0,0,0,1,6,             1,6,0,2,0,9));   // MAX_PC itself is valid
        q.push_back(v(1,0,1,0,0,0,             0,0,1,6,0,9));
        q.push_back(v(1,0,0,1,0,0,             0,0,0,6,1,10));
        q.push_back(v(1,1,0,0,0,0,             0,0,0,6,1,10));  // start ignored in HALT
        q.push_back(v(1,0,0,0,1,0,             1,0,0,6,0,10));
        q.push_back(v(0,0,1,0,0,0,             0,0,0,0,0,0));   // reset mid-fetch
        q.push_back(v(1,0,0,0,1,3,             0,0,0,0,0,0));   // redirect ignored in IDLE
        q.push_back(v(1,1,0,0,0,0,             1,0,0,0,0,0));
        q.push_back(v(1,0,1,0,0,0,             0,0,1,0,0,0));

        for (int i = 0; i < q.size(); i++) begin
            row = i;
            rst_n = q[i].r; start = q[i].s;
            bus.imem_ready = q[i].ir; bus.dec_ready = q[i].dr;
            bus.redirect = q[i].rd; bus.redirect_pc = q[i].rpc;
            @(posedge clk);
            #1;
            chk("imem_req", {31'd0, bus.imem_req}, {31'd0, q[i].ereq});
            if (q[i].ereq) chk("imem_addr", bus.imem_addr, q[i].eaddr);
            chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, q[i].ev});
            chk("inst_pc", bus.inst_pc, q[i].eipc);
            if (q[i].ev) chk("inst", bus.inst, {16'hC0DE, q[i].eipc[15:0]});
            chk("halted", {31'd0, halted}, {31'd0, q[i].eh});
            chk("inst_count", {16'd0, inst_count}, {16'd0, q[i].ecnt});
            if (!q[i].r) chk("inst_rst", bus.inst, 32'd0);
        end

        // In HOLD: input changes between edges must not move any output.
        row = -1;
        start = 1'b0;
        bus.imem_ready = 1'b0; bus.dec_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 32'd4;
        #2;
        chk("moore_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("moore_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("hold_redir_req", {31'd0, bus.imem_req}, 32'd1);
        chk("hold_redir_addr", bus.imem_addr, 32'd4);
        chk("hold_redir_cnt", {16'd0, inst_count}, 32'd1);
        bus.redirect = 1'b0; bus.dec_ready = 1'b0;
        bus.imem_ready = 1'b1;
        #2;
        chk("moore_fetch_valid", {31'd0, bus.inst_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("fetch4_pc", bus.inst_pc, 32'd4);
        chk("fetch4_inst", bus.inst, 32'hC0DE_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
